// File: rtl/vga_pkg.sv
// Shared 800x600@72 raster timing constants and the signed coordinate type.
// Both the timing generator and the colour generators take their numbers from here.
package vga_pkg;

  localparam int HACTIVE = 800;
  localparam int HFP     = 56;
  localparam int HSYNC   = 120;
  localparam int HBP     = 64;
  localparam int VACTIVE = 600;
  localparam int VFP     = 37;
  localparam int VSYNC   = 6;
  localparam int VBP     = 23;
  localparam bit HS_POL  = 1'b1;
  localparam bit VS_POL  = 1'b1;
  localparam int PIPE    = 1;

  localparam int COORD_W = 11;
  localparam int CNT_W   = 8;

  typedef logic signed [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_if.sv
// Raster outputs of the timing generator.
// The generator drives the master modport, and the colour and output stages use the slave modport.
interface vga_timing_if;
  import vga_pkg::*;

  coord_t             spotX;
  coord_t             spotY;
  logic               hs;
  logic               vs;
  logic               blank;
  logic               frame_tick;
  logic [CNT_W-1:0]   frame_cnt;

  modport master (output spotX, spotY, hs, vs, blank, frame_tick, frame_cnt);
  modport slave  (input  spotX, spotY, hs, vs, blank, frame_tick, frame_cnt);

endinterface

// File: rtl/sync_delay.sv
// Generic W-bit, PIPE-deep delay line with asynchronous reset to a supplied value.
// When PIPE is 0, the input passes through combinationally.
module sync_delay #(
  parameter int W    = 1,
  parameter int PIPE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (PIPE == 0) begin : g_pass
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] stage [PIPE];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < PIPE; i++) stage[i] <= rst_val;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[PIPE-1];
  end

endmodule

// File: rtl/vga_timing.sv
// Raster scan generator: signed spot coordinates with blanking ahead of the active area,
// pipelined hs/vs/blank to match the colour generators, and a per-frame tick/counter.
module vga_timing
  import vga_pkg::*;
#(
  parameter int HACTIVE = vga_pkg::HACTIVE,
  parameter int HFP     = vga_pkg::HFP,
  parameter int HSYNC   = vga_pkg::HSYNC,
  parameter int HBP     = vga_pkg::HBP,
  parameter int VACTIVE = vga_pkg::VACTIVE,
  parameter int VFP     = vga_pkg::VFP,
  parameter int VSYNC   = vga_pkg::VSYNC,
  parameter int VBP     = vga_pkg::VBP,
  parameter bit HS_POL  = vga_pkg::HS_POL,
  parameter bit VS_POL  = vga_pkg::VS_POL,
  parameter int PIPE    = vga_pkg::PIPE
) (
  input  logic          clk,
  input  logic          reset,
  vga_timing_if.master  vga
);

  localparam int HB = HFP + HSYNC + HBP;
  localparam int VB = VFP + VSYNC + VBP;

  if (HB > 1024 || VB > 1024 || HACTIVE > 1023 || VACTIVE > 1023) begin : g_bad_timing
    $error("vga_timing: timing parameters exceed the signed 11-bit coordinate range");
  end

  // Blanking sits at negative coordinates, so front porch starts at -HB / -VB.
  localparam coord_t X_FIRST  = coord_t'(-HB);
  localparam coord_t X_LAST   = coord_t'(HACTIVE - 1);
  localparam coord_t HS_FIRST = coord_t'(HFP - HB);
  localparam coord_t HS_LAST  = coord_t'(HFP + HSYNC - 1 - HB);
  localparam coord_t Y_FIRST  = coord_t'(-VB);
  localparam coord_t Y_LAST   = coord_t'(VACTIVE - 1);
  localparam coord_t VS_FIRST = coord_t'(VFP - VB);
  localparam coord_t VS_LAST  = coord_t'(VFP + VSYNC - 1 - VB);

  coord_t           spot_x;
  coord_t           spot_y;
  logic             frame_tick;
  logic [CNT_W-1:0] frame_cnt;
  logic             x_end;
  logic             y_end;
  logic             frame_end;
  logic             hs_raw;
  logic             vs_raw;
  logic             blank_raw;
  logic [2:0]       sync_q;

  assign x_end     = (spot_x == X_LAST);
  assign y_end     = (spot_y == Y_LAST);
  assign frame_end = x_end && y_end;

  // The tick is registered off the wrap, so it lands on the first pixel of the new frame
  // and never fires in the first cycle after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spot_x     <= X_FIRST;
      spot_y     <= Y_FIRST;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (x_end) begin
        spot_x <= X_FIRST;
        spot_y <= y_end ? Y_FIRST : spot_y + coord_t'(1);
      end else begin
        spot_x <= spot_x + coord_t'(1);
      end
      frame_tick <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  assign hs_raw    = (spot_x >= HS_FIRST && spot_x <= HS_LAST) ? HS_POL : !HS_POL;
  assign vs_raw    = (spot_y >= VS_FIRST && spot_y <= VS_LAST) ? VS_POL : !VS_POL;
  assign blank_raw = spot_x[COORD_W-1] | spot_y[COORD_W-1];

  sync_delay #(
    .W    (3),
    .PIPE (PIPE)
  ) u_sync_delay (
    .clk     (clk),
    .reset   (reset),
    .rst_val ({!HS_POL, !VS_POL, 1'b1}),
    .d       ({hs_raw, vs_raw, blank_raw}),
    .q       (sync_q)
  );

  assign vga.spotX      = spot_x;
  assign vga.spotY      = spot_y;
  assign vga.hs         = sync_q[2];
  assign vga.vs         = sync_q[1];
  assign vga.blank      = sync_q[0];
  assign vga.frame_tick = frame_tick;
  assign vga.frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing using a shrunken raster so that many frames fit in a short run.
// A reference raster model feeds a queue of expected hs/vs/blank values that is drained PIPE cycles later.
module tb_vga_timing;

  // Small raster: HB=7, line=15 clk, VB=5, 11 lines, frame=165 clk.
  localparam int T_HACTIVE = 8;
  localparam int T_HFP     = 2;
  localparam int T_HSYNC   = 3;
  localparam int T_HBP     = 2;
  localparam int T_VACTIVE = 6;
  localparam int T_VFP     = 2;
  localparam int T_VSYNC   = 2;
  localparam int T_VBP     = 1;
  localparam int T_FRAME   = 165;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  vga_timing_if vga ();

  vga_timing #(
    .HACTIVE (T_HACTIVE),
    .HFP     (T_HFP),
    .HSYNC   (T_HSYNC),
    .HBP     (T_HBP),
    .VACTIVE (T_VACTIVE),
    .VFP     (T_VFP),
    .VSYNC   (T_VSYNC),
    .VBP     (T_VBP),
    .HS_POL  (1'b1),
    .VS_POL  (1'b1),
    .PIPE    (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vga   (vga)
  );

  int total = 0;
  int bad   = 0;

  logic signed [10:0] mx;
  logic signed [10:0] my;
  logic               mtick;
  logic [7:0]         mcnt;
  logic [2:0]         exp_q[$];

  int n_blank_low;
  int n_hs_high;
  int n_vs_high;
  int n_ticks;

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // H sync covers x=-5..-3 and V sync covers y=-3..-2 in this raster.
  function automatic logic [2:0] raw_sync(input logic signed [10:0] x, input logic signed [10:0] y);
    logic h;
    logic v;
    logic b;
    h = (x >= -11'sd5) && (x <= -11'sd3);
    v = (y >= -11'sd3) && (y <= -11'sd2);
    b = (x < 0) || (y < 0);
    return {h, v, b};
  endfunction

  task automatic model_reset();
    mx    = -11'sd7;
    my    = -11'sd5;
    mtick = 1'b0;
    mcnt  = 8'd0;
    exp_q.delete();
    exp_q.push_back(3'b001);
  endtask

  task automatic step_model();
    logic wrap;
    wrap = (mx == 11'sd7) && (my == 11'sd5);
    if (mx == 11'sd7) begin
      mx = -11'sd7;
      my = (my == 11'sd5) ? -11'sd5 : my + 11'sd1;
    end else begin
      mx = mx + 11'sd1;
    end
    mtick = wrap;
    if (wrap) mcnt = mcnt + 8'd1;
  endtask

  task automatic check_output();
    logic [2:0] exp_sync;
    check_val("spotX", vga.spotX, mx);
    check_val("spotY", vga.spotY, my);
    check_val("frame_tick", {31'd0, vga.frame_tick}, {31'd0, mtick});
    check_val("frame_cnt", {24'd0, vga.frame_cnt}, {24'd0, mcnt});
    exp_q.push_back(raw_sync(mx, my));
    exp_sync = exp_q.pop_front();
    check_val("hs", {31'd0, vga.hs}, {31'd0, exp_sync[2]});
    check_val("vs", {31'd0, vga.vs}, {31'd0, exp_sync[1]});
    check_val("blank", {31'd0, vga.blank}, {31'd0, exp_sync[0]});
    if (!vga.blank) n_blank_low++;
    if (vga.hs) n_hs_high++;
    if (vga.vs) n_vs_high++;
    if (vga.frame_tick) n_ticks++;
  endtask

  task automatic apply_stimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_output();
      step_model();
      @(negedge clk);
    end
  endtask

  task automatic clear_counts();
    n_blank_low = 0;
    n_hs_high   = 0;
    n_vs_high   = 0;
    n_ticks     = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_spotX"}, vga.spotX, -32'sd7);
    check_val({tag, "_spotY"}, vga.spotY, -32'sd5);
    check_val({tag, "_hs"}, {31'd0, vga.hs}, 32'sd0);
    check_val({tag, "_vs"}, {31'd0, vga.vs}, 32'sd0);
    check_val({tag, "_blank"}, {31'd0, vga.blank}, 32'sd1);
    check_val({tag, "_tick"}, {31'd0, vga.frame_tick}, 32'sd0);
    check_val({tag, "_cnt"}, {24'd0, vga.frame_cnt}, 32'sd0);
  endtask

  initial begin
    logic [7:0] prev_cnt;
    logic       wrap_seen;

    $display("[TB] reset state");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    model_reset();
    clear_counts();

    $display("[TB] first frame, then one full frame of sync/blank measurement");
    apply_stimulus(T_FRAME);
    check_val("ticks_first_frame", n_ticks, 32'sd0);
    clear_counts();
    apply_stimulus(T_FRAME);
    check_val("blank_low_per_frame", n_blank_low, 32'sd48);
    check_val("hs_high_per_frame", n_hs_high, 32'sd33);
    check_val("vs_high_per_frame", n_vs_high, 32'sd30);
    check_val("ticks_second_frame", n_ticks, 32'sd1);

    $display("[TB] asynchronous reset in the active area");
    apply_stimulus(115);
    check_val("pre_reset_spotX", vga.spotX, 32'sd3);
    check_val("pre_reset_spotY", vga.spotY, 32'sd2);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    check_reset_values("mid_rst_hold");
    reset = 1'b0;
    model_reset();
    clear_counts();
    apply_stimulus(T_FRAME + 20);
    check_val("ticks_after_mid_reset", n_ticks, 32'sd1);

    $display("[TB] 257 frames for frame counter wrap");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_counts();
    wrap_seen = 1'b0;
    prev_cnt  = vga.frame_cnt;
    for (int i = 0; i <= 257 * T_FRAME; i++) begin
      if (vga.frame_tick) begin
        n_ticks++;
        if (prev_cnt == 8'd255 && vga.frame_cnt == 8'd0) wrap_seen = 1'b1;
      end
      prev_cnt = vga.frame_cnt;
      @(negedge clk);
    end
    check_val("tick_count_257", n_ticks, 32'sd257);
    check_val("cnt_wrap_seen", {31'd0, wrap_seen}, 32'sd1);
    check_val("cnt_after_257", {24'd0, vga.frame_cnt}, 32'sd1);
    check_val("spotX_after_257", vga.spotX, -32'sd6);
    check_val("spotY_after_257", vga.spotY, -32'sd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
